// File: rtl/hidden_ctrl_pkg.sv
// Shared types and constants for the hidden-layer sequencer.
package hidden_ctrl_pkg;

    localparam int FP16_W = 16;
    localparam int IMG_W  = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        EVAL  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // States in which the host may start a new weight load.
    function automatic logic is_host_state(input state_t s);
        return (s == IDLE) || (s == READY);
    endfunction

endpackage

// File: rtl/hidden_load_addr_gen.sv
// Weight-load beat sequencer: tracks (neuron, address) of the next beat,
// address-major within a neuron, and flags the final beat of the whole bank.
// The position holds on the final beat instead of wrapping; only clr restarts it.
module hidden_load_addr_gen
    import hidden_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int N_WEIGHTS   = 64,
    localparam int ADDR_W     = $clog2(N_WEIGHTS),
    localparam int NIDX_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [NIDX_W-1:0] neuron_idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NIDX_W-1:0] nidx_q, nidx_d;
    logic              addr_wrap;

    assign addr_wrap  = (addr_q == ADDR_W'(N_WEIGHTS - 1));
    assign last       = addr_wrap && (nidx_q == NIDX_W'(NUM_NEURONS - 1));
    assign neuron_idx = nidx_q;
    assign addr       = addr_q;

    // Next beat position: restart on clr, otherwise step on each accepted beat.
    always_comb begin
        addr_d = addr_q;
        nidx_d = nidx_q;
        if (clr) begin
            addr_d = '0;
            nidx_d = '0;
        end else if (adv && !last) begin
            if (addr_wrap) begin
                addr_d = '0;
                nidx_d = nidx_q + NIDX_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // Beat position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            nidx_q <= '0;
        end else begin
            addr_q <= addr_d;
            nidx_q <= nidx_d;
        end
    end

endmodule

// File: rtl/hidden_layer_ctrl.sv
// Sequencer for a bank of hidden-layer neurons sharing one weight-write bus.
// Streams weights into every neuron, then runs one evaluation per image and
// holds the captured neuron outputs until the consumer takes them.
// rst is asynchronous and active-low.
// Optional build macro: HIDDEN_CTRL_PERF_EN adds perf_infer_cnt, a free-running
// count of result handshakes (cleared only by reset).
module hidden_layer_ctrl
    import hidden_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int N_WEIGHTS   = 64,
    parameter int EVAL_LAT    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [FP16_W-1:0]             w_data,
    input  logic                          img_valid,
    output logic                          img_ready,
    input  logic [IMG_W-1:0]              img_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [FP16_W*NUM_NEURONS-1:0] res_data,
    output logic [NUM_NEURONS-1:0]        n_wen,
    output logic [FP16_W-1:0]             n_weight,
    output logic [$clog2(N_WEIGHTS)-1:0]  n_addr,
    output logic                          n_en,
    output logic [IMG_W-1:0]              n_image,
    input  logic [FP16_W*NUM_NEURONS-1:0] n_out,
    output logic                          weights_loaded,
    output logic                          busy
`ifdef HIDDEN_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_infer_cnt
`endif
);

    localparam int ADDR_W = $clog2(N_WEIGHTS);
    localparam int NIDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int RES_W  = FP16_W * NUM_NEURONS;

    state_t                   state_q, state_d;
    logic [3:0]               lat_q, lat_d;
    logic [NUM_NEURONS-1:0]   n_wen_q, n_wen_d;
    logic [FP16_W-1:0]        n_weight_q, n_weight_d;
    logic [ADDR_W-1:0]        n_addr_q, n_addr_d;
    logic                     n_en_q, n_en_d;
    logic [IMG_W-1:0]         n_image_q, n_image_d;
    logic [RES_W-1:0]         res_data_q, res_data_d;
    logic                     loaded_q, loaded_d;

    logic                     load_clr;
    logic                     beat_acc;
    logic [NIDX_W-1:0]        gen_nidx;
    logic [ADDR_W-1:0]        gen_addr;
    logic                     gen_last;

    hidden_load_addr_gen #(
        .NUM_NEURONS (NUM_NEURONS),
        .N_WEIGHTS   (N_WEIGHTS)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (load_clr),
        .adv        (beat_acc),
        .neuron_idx (gen_nidx),
        .addr       (gen_addr),
        .last       (gen_last)
    );

    // Next-state and handshake decode; all neuron-side buses are registered.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        n_wen_d    = '0;
        n_weight_d = n_weight_q;
        n_addr_d   = n_addr_q;
        n_en_d     = 1'b0;
        n_image_d  = n_image_q;
        res_data_d = res_data_q;
        loaded_d   = loaded_q;
        load_clr   = 1'b0;
        beat_acc   = 1'b0;
        w_ready    = 1'b0;
        img_ready  = 1'b0;
        res_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    load_clr = 1'b1;
                    loaded_d = 1'b0;
                end
            end

            LOAD: begin
                w_ready  = 1'b1;
                beat_acc = w_valid;
                if (w_valid) begin
                    n_wen_d    = NUM_NEURONS'(1) << gen_nidx;
                    n_weight_d = w_data;
                    n_addr_d   = gen_addr;
                    if (gen_last) begin
                        state_d  = READY;
                        loaded_d = 1'b1;
                    end
                end
            end

            READY: begin
                // A simultaneous load request takes priority over an image,
                // so the image handshake is withheld in that cycle.
                if (load_start) begin
                    state_d  = LOAD;
                    load_clr = 1'b1;
                    loaded_d = 1'b0;
                end else begin
                    img_ready = 1'b1;
                    if (img_valid) begin
                        n_image_d = img_data;
                        n_en_d    = 1'b1;
                        lat_d     = '0;
                        state_d   = EVAL;
                    end
                end
            end

            EVAL: begin
                // lat_q counts cycles since the n_en cycle; outputs are
                // valid EVAL_LAT cycles after it and captured at that edge.
                if (lat_q == 4'(EVAL_LAT)) begin
                    res_data_d = n_out;
                    state_d    = RESP;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end

            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = READY;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and status registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            n_wen_q    <= '0;
            n_weight_q <= '0;
            n_addr_q   <= '0;
            n_en_q     <= 1'b0;
            n_image_q  <= '0;
            res_data_q <= '0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            n_wen_q    <= n_wen_d;
            n_weight_q <= n_weight_d;
            n_addr_q   <= n_addr_d;
            n_en_q     <= n_en_d;
            n_image_q  <= n_image_d;
            res_data_q <= res_data_d;
            loaded_q   <= loaded_d;
        end
    end

    assign n_wen          = n_wen_q;
    assign n_weight       = n_weight_q;
    assign n_addr         = n_addr_q;
    assign n_en           = n_en_q;
    assign n_image        = n_image_q;
    assign res_data       = res_data_q;
    assign weights_loaded = loaded_q;
    assign busy           = !is_host_state(state_q);

`ifdef HIDDEN_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        res_hs;

    assign res_hs = (state_q == RESP) && res_ready;

    // Inference counter: one per result handshake, wraps naturally.
    always_comb begin
        perf_d = perf_q;
        if (res_hs) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Inference counter register; untouched by load_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_infer_cnt = perf_q;
`else
    // No inference counter in this build.
`endif

endmodule

// File: tb/tb_hidden_layer_ctrl.sv
// Self-checking bench for hidden_layer_ctrl (NUM_NEURONS=8, N_WEIGHTS=64, EVAL_LAT=2).
// Optional build macro: HIDDEN_CTRL_PERF_EN enables the inference counter check.
module tb_hidden_layer_ctrl;

    localparam int NN  = 8;
    localparam int NW  = 64;
    localparam int LAT = 2;

    typedef struct packed {
        logic [NN-1:0] wen;
        logic [5:0]    addr;
        logic [15:0]   w;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load_start = 1'b0;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [15:0]     w_data = '0;
    logic            img_valid = 1'b0;
    logic            img_ready;
    logic [63:0]     img_data = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [16*NN-1:0] res_data;
    logic [NN-1:0]   n_wen;
    logic [15:0]     n_weight;
    logic [5:0]      n_addr;
    logic            n_en;
    logic [63:0]     n_image;
    logic [16*NN-1:0] n_out;
    logic            weights_loaded;
    logic            busy;
`ifdef HIDDEN_CTRL_PERF_EN
    logic [31:0]     perf_infer_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    hidden_layer_ctrl #(
        .NUM_NEURONS (NN),
        .N_WEIGHTS   (NW),
        .EVAL_LAT    (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .img_valid      (img_valid),
        .img_ready      (img_ready),
        .img_data       (img_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .n_wen          (n_wen),
        .n_weight       (n_weight),
        .n_addr         (n_addr),
        .n_en           (n_en),
        .n_image        (n_image),
        .n_out          (n_out),
        .weights_loaded (weights_loaded),
        .busy           (busy)
`ifdef HIDDEN_CTRL_PERF_EN
        ,
        .perf_infer_cnt (perf_infer_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Neuron model output for one neuron given the image.
    function automatic logic [15:0] nmodel(input logic [63:0] img, input int j);
        logic [15:0] v;
        v = img[(j % 4) * 16 +: 16];
        return v + 16'(j * 257 + 1);
    endfunction

    function automatic logic [16*NN-1:0] exp_res(input logic [63:0] img);
        logic [16*NN-1:0] r;
        r = '0;
        for (int j = 0; j < NN; j++) r[16*j +: 16] = nmodel(img, j);
        return r;
    endfunction

    // Neuron array model: outputs are meaningful only LAT cycles after n_en.
    logic [15:0] en_pipe;
    always @(posedge clk or negedge rst) begin
        if (!rst) en_pipe <= '0;
        else      en_pipe <= {en_pipe[14:0], n_en};
    end

    always_comb begin
        n_out = '0;
        for (int j = 0; j < NN; j++) begin
            n_out[16*j +: 16] = en_pipe[LAT-1] ? nmodel(n_image, j) : (16'hBAD0 ^ 16'(j));
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    wr_t              wr_q[$];
    logic [16*NN-1:0] res_q[$];
    int               mon_beat = 0;
    int               wr_cnt   = 0;
    int               en_len   = 0;
    int               en_cyc   = 0;
    logic             en_prev  = 1'b0;
    logic             rv_prev  = 1'b0;

    always @(negedge clk) begin
        wr_t              e;
        logic [16*NN-1:0] r;
        if (!rst) begin
            wr_q.delete();
            res_q.delete();
            mon_beat = 0;
            en_len   = 0;
            en_prev  = 1'b0;
            rv_prev  = 1'b0;
        end else begin
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                check("wr_beat", {n_wen, n_addr, n_weight}, {e.wen, e.addr, e.w});
                if (n_wen != '0) wr_cnt++;
            end else if (n_wen != '0) begin
                check("wr_unexp", n_wen, '0);
            end
            if (load_start && !busy) mon_beat = 0;
            if (w_valid && w_ready) begin
                e.wen  = NN'(1) << (mon_beat / NW);
                e.addr = 6'(mon_beat % NW);
                e.w    = w_data;
                wr_q.push_back(e);
                mon_beat++;
            end

            if (n_en) begin
                if (!en_prev) en_cyc = cyc;
                en_len++;
            end else if (en_prev) begin
                check("n_en_width", en_len, 1);
                en_len = 0;
            end
            en_prev = n_en;

            if (res_valid && !rv_prev) check("res_latency", cyc - en_cyc, LAT + 1);
            rv_prev = res_valid;

            if (res_valid && res_ready) begin
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    check("res_data", res_data, r);
                end else begin
                    check("res_unexp", res_valid, 1'b0);
                end
            end
            if (img_valid && img_ready) res_q.push_back(exp_res(img_data));
        end
    end

    task automatic chk_zero(input string tag);
        check({tag, "_ctrl"}, {w_ready, img_ready, res_valid, n_en, busy, weights_loaded, n_wen}, '0);
        check({tag, "_res"},  res_data, '0);
        check({tag, "_bus"},  {n_weight, n_addr, n_image}, '0);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic drive_beats(input bit toggle, input int n);
        int k = 0;
        int t = 0;
        bit hs;
        while (k < n && t < 4 * n + 20) begin
            w_valid = toggle ? ((t % 2) == 0) : 1'b1;
            w_data  = w_valid ? 16'(k) : 16'hFFFF;
            hs = w_valid && w_ready;
            if (k == 100 && hs) check("loaded_during", weights_loaded, 1'b0);
            @(posedge clk); #1;
            if (hs) k++;
            t++;
        end
        w_valid = 1'b0;
        if (k < n) check("beat_timeout", k, n);
    endtask

    task automatic wait_img_ready();
        int t = 0;
        while (!img_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!img_ready) check("img_ready_timeout", img_ready, 1'b1);
    endtask

    task automatic send_image(input logic [63:0] d);
        wait_img_ready();
        img_valid = 1'b1;
        img_data  = d;
        @(posedge clk); #1;
        img_valid = 1'b0;
    endtask

    task automatic wait_res_valid();
        int t = 0;
        while (!res_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!res_valid) check("res_valid_timeout", res_valid, 1'b1);
    endtask

    initial begin
        int base;
        int acc;
        int prev;
        logic [16*NN-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("idle");

        // Full load, w_valid always high.
        base = wr_cnt;
        start_load();
        check("load_wready", w_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        drive_beats(1'b0, NN * NW);
        check("loaded_a", weights_loaded, 1'b1);
        check("ready_a", {busy, w_ready, img_ready}, 3'b001);
        @(negedge clk); #1;
        check("wr_count_a", wr_cnt - base, NN * NW);
        @(posedge clk); #1;

        // load_start and img_valid together in READY: load wins.
        load_start = 1'b1;
        img_valid  = 1'b1;
        img_data   = 64'h0123_4567_89AB_CDEF;
        #1;
        check("coll_img_ready", img_ready, 1'b0);
        @(posedge clk); #1;
        load_start = 1'b0;
        img_valid  = 1'b0;
        check("coll_state", {w_ready, busy, weights_loaded}, 3'b110);

        // Reset in the middle of a load.
        drive_beats(1'b0, 300);
        rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full load with gaps between beats.
        base = wr_cnt;
        start_load();
        drive_beats(1'b1, NN * NW);
        check("loaded_b", weights_loaded, 1'b1);
        @(negedge clk); #1;
        check("wr_count_b", wr_cnt - base, NN * NW);
        @(posedge clk); #1;

        // Directed image.
        res_ready = 1'b1;
        send_image(64'hFFFF_0000_0000_0001);
        check("eval_busy", busy, 1'b1);
        wait_res_valid();
        @(posedge clk); #1;

        // Back-to-back images with res_ready tied high.
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_img_ready();
            img_valid = 1'b1;
            img_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            img_valid = 1'b0;
            acc = cyc;
            if (i > 0) check("throughput", acc - prev, LAT + 3);
            prev = acc;
        end
        wait_res_valid();
        @(posedge clk); #1;

        // Back-pressure on the result.
        res_ready = 1'b0;
        send_image({$urandom, $urandom});
        wait_res_valid();
        held = res_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_valid", res_valid, 1'b1);
            check("stall_data", res_data, held);
            check("stall_img_ready", img_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("after_resp", {res_valid, img_ready}, 2'b01);

`ifdef HIDDEN_CTRL_PERF_EN
        check("perf_cnt", perf_infer_cnt, 32'd5);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", wr_q.size() + res_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
